seq_restoring_divider: RTL and testbench

- Sequential restoring divider, one quotient bit per clock.
- Inverse of the team's shift-and-add multiplier datapath: divides a 2N-bit dividend (a multiplier product) by an N-bit divisor.
- Produces an N-bit quotient and an N-bit remainder.
- Lives beside the multiplier in the arithmetic unit; shares the same start/done control style with the controller FSM.

---
 rtl/seq_restoring_divider_if.sv | 25 ++
 rtl/seq_restoring_divider.sv | 119 +++++++++++
 tb/tb_seq_restoring_divider.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/seq_restoring_divider_if.sv
// Start/done handshake and result bus of the sequential restoring divider.
// The master drives operands and start; the divider (slave) returns results and status.
interface seq_restoring_divider_if #(
   parameter int N = 16
);
   logic             start;
   logic [2*N-1:0]   dividend;
   logic [N-1:0]     divisor;
   logic             busy;
   logic             done;
   logic [N-1:0]     quotient;
   logic [N-1:0]     remainder;
   logic             div_by_zero;
   logic             overflow;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero, overflow
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero, overflow
   );
endinterface

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Zero divisors and quotients wider than N bits bypass the iteration via a one-cycle FINISH state.
module seq_restoring_divider #(
   parameter int N = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   seq_restoring_divider_if.slave bus
);
   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

   state_t         r_state;
   logic [N-1:0]   r_rem;
   logic [N-1:0]   r_q;
   logic [N-1:0]   r_dvs;
   logic [CW-1:0]  r_cnt;
   logic           r_dbz_pend;
   logic           r_busy;
   logic           r_done;
   logic [N-1:0]   r_quot;
   logic [N-1:0]   r_remd;
   logic           r_dbz;
   logic           r_ovf;

   logic [N-1:0]   w_hi;
   logic [N:0]     w_t;
   logic [N:0]     w_diff;
   logic           w_ge;
   logic [N-1:0]   w_rnext;
   logic [N-1:0]   w_qnext;
   logic           w_unused;

   assign w_hi = bus.dividend[2*N-1:N];

   // The trial value is N+1 bits so the bit shifted out of the partial remainder takes part in the compare.
   always_comb begin
      w_t     = {r_rem, r_q[N-1]};
      w_diff  = w_t - {1'b0, r_dvs};
      w_ge    = (w_t >= {1'b0, r_dvs});
      w_rnext = w_ge ? w_diff[N-1:0] : w_t[N-1:0];
      w_qnext = {r_q[N-2:0], w_ge};
   end

   // After a successful subtract the difference is below the divisor, so its top bit is always zero.
   assign w_unused = w_diff[N];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_rem      <= '0;
         r_q        <= '0;
         r_dvs      <= '0;
         r_cnt      <= '0;
         r_dbz_pend <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_quot     <= '0;
         r_remd     <= '0;
         r_dbz      <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_dvs      <= bus.divisor;
                  r_rem      <= w_hi;
                  r_q        <= bus.dividend[N-1:0];
                  r_cnt      <= '0;
                  r_busy     <= 1'b1;
                  r_dbz_pend <= (bus.divisor == '0);
                  if (bus.divisor == '0 || w_hi >= bus.divisor) begin
                     r_state <= S_FINISH;
                  end else begin
                     r_state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               r_rem <= w_rnext;
               r_q   <= w_qnext;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(N-1)) begin
                  r_quot  <= w_qnext;
                  r_remd  <= w_rnext;
                  r_dbz   <= 1'b0;
                  r_ovf   <= 1'b0;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            S_FINISH: begin
               // r_q still holds the captured low dividend half, which is the divide-by-zero remainder.
               r_quot  <= '1;
               r_remd  <= r_dbz_pend ? r_q : '0;
               r_dbz   <= r_dbz_pend;
               r_ovf   <= ~r_dbz_pend;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.quotient    = r_quot;
   assign bus.remainder   = r_remd;
   assign bus.div_by_zero = r_dbz;
   assign bus.overflow    = r_ovf;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: directed vector table, start/reset corner sequences,
// and a chained random run checked against an arithmetic reference model.
module tb_seq_restoring_divider;
   localparam int N = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;

   seq_restoring_divider_if #(.N(N)) bus ();

   seq_restoring_divider #(.N(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] dd;
      logic [15:0] dv;
      logic [15:0] q;
      logic [15:0] r;
      logic        dbz;
      logic        ovf;
      int          lat;
   } vec_t;

   vec_t tbl[8];

   function automatic void model(input logic [31:0] dd, input logic [15:0] dv,
                                 output logic [15:0] q, output logic [15:0] r,
                                 output logic dbz, output logic ovf);
      if (dv == 16'd0) begin
         q = 16'hFFFF; r = dd[15:0]; dbz = 1'b1; ovf = 1'b0;
      end else if (dd[31:16] >= dv) begin
         q = 16'hFFFF; r = 16'h0000; dbz = 1'b0; ovf = 1'b1;
      end else begin
         q = 16'(dd / {16'd0, dv});
         r = 16'(dd % {16'd0, dv});
         dbz = 1'b0; ovf = 1'b0;
      end
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge with operands scrambled.
   task automatic launch(input logic [31:0] dd, input logic [15:0] dv);
      bus.start    = 1'b1;
      bus.dividend = dd;
      bus.divisor  = dv;
      @(posedge clk);
      @(negedge clk);
      bus.start    = 1'b0;
      bus.dividend = $urandom;
      bus.divisor  = 16'($urandom);
   endtask

   task automatic wait_done(output int lat, output int busyc, output bit ok);
      lat   = 0;
      busyc = bus.busy ? 1 : 0;
      ok    = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (bus.done) begin
            ok = 1'b1;
            break;
         end
         if (bus.busy) busyc++;
      end
   endtask

   task automatic chk_result(input string nm, input logic [15:0] q, input logic [15:0] r,
                             input logic dbz, input logic ovf);
      chk({nm, "_quot"}, 32'(bus.quotient), 32'(q));
      chk({nm, "_rem"},  32'(bus.remainder), 32'(r));
      chk({nm, "_dbz"},  32'(bus.div_by_zero), 32'(dbz));
      chk({nm, "_ovf"},  32'(bus.overflow), 32'(ovf));
   endtask

   logic [31:0] rdd[20];
   logic [15:0] rdv[20];

   initial begin
      int lat, busyc, dcount, prev_cyc;
      bit ok;
      logic [15:0] mq, mr, hi;
      logic mdbz, movf;

      tbl[0] = '{32'd100,       16'd7,     16'd14,    16'd2,     1'b0, 1'b0, N};
      tbl[1] = '{32'hFFFE0001,  16'hFFFF,  16'hFFFF,  16'h0000,  1'b0, 1'b0, N};
      tbl[2] = '{32'h0000FFFF,  16'd1,     16'hFFFF,  16'h0000,  1'b0, 1'b0, N};
      tbl[3] = '{32'h12345678,  16'd0,     16'hFFFF,  16'h5678,  1'b1, 1'b0, 1};
      tbl[4] = '{32'h00070000,  16'd7,     16'hFFFF,  16'h0000,  1'b0, 1'b1, 1};
      tbl[5] = '{32'd100,       16'd7,     16'd14,    16'd2,     1'b0, 1'b0, N};
      tbl[6] = '{32'd0,         16'd5,     16'd0,     16'd0,     1'b0, 1'b0, N};
      tbl[7] = '{32'h0007ABCD,  16'd0,     16'hFFFF,  16'hABCD,  1'b1, 1'b0, 1};

      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;

      // Outputs while reset is held.
      @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk_result("rst", 16'd0, 16'd0, 1'b0, 1'b0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         launch(tbl[i].dd, tbl[i].dv);
         wait_done(lat, busyc, ok);
         if (!ok) begin
            chk($sformatf("vec%0d_timeout", i), 0, 1);
         end else begin
            chk_result($sformatf("vec%0d", i), tbl[i].q, tbl[i].r, tbl[i].dbz, tbl[i].ovf);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
            chk($sformatf("vec%0d_busy", i), 32'(busyc), 32'(tbl[i].lat));
         end
         @(negedge clk);
         chk($sformatf("vec%0d_done_width", i), 32'(bus.done), 0);
         chk($sformatf("vec%0d_hold", i), 32'(bus.quotient), 32'(tbl[i].q));
      end

      // A start pulse while running must not restart or re-sample operands.
      launch(32'd100, 16'd7);
      repeat (3) @(negedge clk);
      bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 16'd5;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(lat, busyc, ok);
      chk("ignore_ok", 32'(ok), 1);
      chk_result("ignore", 16'd14, 16'd2, 1'b0, 1'b0);
      @(negedge clk);

      // Asynchronous reset mid-run: outputs clear before the next clock edge, no done follows.
      launch(32'd100, 16'd7);
      repeat (8) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("arst_busy", 32'(bus.busy), 0);
      chk_result("arst", 16'd0, 16'd0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      dcount = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus.done) dcount++;
      end
      chk("arst_no_done", 32'(dcount), 0);
      chk("arst_idle_busy", 32'(bus.busy), 0);

      // Chained random normal-path divisions, each started in the previous done cycle.
      for (int i = 0; i < 20; i++) begin
         rdv[i] = 16'($urandom_range(1, 65535));
         hi     = 16'($urandom_range(0, int'(rdv[i]) - 1));
         rdd[i] = {hi, 16'($urandom)};
      end
      prev_cyc = 0;
      launch(rdd[0], rdv[0]);
      for (int i = 0; i < 20; i++) begin
         wait_done(lat, busyc, ok);
         if (!ok) begin
            chk($sformatf("rnd%0d_timeout", i), 0, 1);
            break;
         end
         model(rdd[i], rdv[i], mq, mr, mdbz, movf);
         chk_result($sformatf("rnd%0d", i), mq, mr, mdbz, movf);
         chk($sformatf("rnd%0d_inv", i),
             32'(bus.quotient) * 32'(rdv[i]) + 32'(bus.remainder), rdd[i]);
         chk($sformatf("rnd%0d_rem_lt", i), 32'(bus.remainder < rdv[i]), 1);
         chk($sformatf("rnd%0d_lat", i), 32'(lat), N);
         if (i > 0) chk($sformatf("rnd%0d_spacing", i), 32'(cyc - prev_cyc), N + 1);
         prev_cyc = cyc;
         if (i < 19) launch(rdd[i+1], rdv[i+1]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
